div_seq: RTL and testbench

//   Iterative RV32M divide sequencer beside the EX stage. Runs a radix-2

---
 rtl/div_seq_pkg.sv | 48 ++++
 rtl/div_seq.sv | 162 ++++++++++++++++
 tb/tb_div_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared types, sizes and result helpers for the iterative RV32M divider.
package div_seq_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Signed variants treat operands as two's complement.
  function automatic logic is_signed_op(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Remainder variants return the remainder instead of the quotient.
  function automatic logic is_rem_op(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Apply the sign fix-ups and pick quotient or remainder for the op.
  function automatic logic [WIDTH-1:0] select_result(
    input div_op_e          op,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] rem,
    input logic             q_neg,
    input logic             r_neg
  );
    logic [WIDTH-1:0] q_f;
    logic [WIDTH-1:0] r_f;
    q_f = q_neg ? (-quo) : quo;
    r_f = r_neg ? (-rem) : rem;
    return is_rem_op(op) ? r_f : q_f;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU with pipeline stall.
module div_seq
  import div_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             stallreq_o
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  div_op_e          op_q, op_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             stall_c;
  logic             sgn_c;
  div_op_e          op_in_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic [WIDTH:0]   rem_sh_c, trial_c;
  logic [WIDTH-1:0] quo_sh_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_q     <= OP_DIV;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      result_q <= result_d;
    end
  end

  // Next-state, one quotient bit per CALC cycle, and result/flag generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    ready_d  = 1'b0;
    result_d = '0;
    stall_c  = 1'b0;

    op_in_c  = div_op_e'(op_i);
    sgn_c    = is_signed_op(op_in_c);
    abs_a_c  = (sgn_c && dividend_i[WIDTH-1]) ? (-dividend_i) : dividend_i;
    abs_b_c  = (sgn_c && divisor_i[WIDTH-1])  ? (-divisor_i)  : divisor_i;
    rem_sh_c = {rem_q, quo_q[WIDTH-1]};
    quo_sh_c = {quo_q[WIDTH-2:0], 1'b0};
    trial_c  = rem_sh_c - {1'b0, dvs_q};

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          stall_c = 1'b1;
          op_d    = op_in_c;
          if (divisor_i == '0) begin
            // Divide by zero: quotient all ones, remainder is the raw dividend.
            quo_d    = ALL_ONES;
            rem_d    = dividend_i;
            q_neg_d  = 1'b0;
            r_neg_d  = 1'b0;
            state_d  = ST_DONE;
            ready_d  = 1'b1;
            result_d = select_result(op_in_c, ALL_ONES, dividend_i, 1'b0, 1'b0);
          end else if (sgn_c && (dividend_i == SIGNED_MIN) && (divisor_i == ALL_ONES)) begin
            // Signed overflow: quotient saturates to the most negative value.
            quo_d    = SIGNED_MIN;
            rem_d    = '0;
            q_neg_d  = 1'b0;
            r_neg_d  = 1'b0;
            state_d  = ST_DONE;
            ready_d  = 1'b1;
            result_d = select_result(op_in_c, SIGNED_MIN, '0, 1'b0, 1'b0);
          end else begin
            quo_d   = abs_a_c;
            rem_d   = '0;
            dvs_d   = abs_b_c;
            cnt_d   = '0;
            q_neg_d = sgn_c & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            r_neg_d = sgn_c & dividend_i[WIDTH-1];
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        stall_c = 1'b1;
        if (!trial_c[WIDTH]) begin
          rem_d = trial_c[WIDTH-1:0];
          quo_d = quo_sh_c | WIDTH'(1);
        end else begin
          rem_d = rem_sh_c[WIDTH-1:0];
          quo_d = quo_sh_c;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d  = ST_DONE;
          ready_d  = 1'b1;
          result_d = select_result(op_q, quo_d, rem_d, q_neg_q, r_neg_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush abandons everything, including a start in the same cycle.
    if (cancel_i) begin
      state_d  = ST_IDLE;
      ready_d  = 1'b0;
      result_d = '0;
      stall_c  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign stallreq_o = stall_c;

endmodule

// File: tb/tb_div_seq.sv
// Randomised and directed check of div_seq against a latency/arithmetic model.
module tb_div_seq;

  localparam logic [1:0] DIV  = 2'd0;
  localparam logic [1:0] DIVU = 2'd1;
  localparam logic [1:0] REM  = 2'd2;
  localparam logic [1:0] REMU = 2'd3;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        cancel_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        stallreq_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        tb_done = 1'b0;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  // Architectural result of an RV32M divide, via 64-bit arithmetic.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    logic   sgn, is_rem;
    sgn    = (op == DIV) || (op == REM);
    is_rem = (op == REM) || (op == REMU);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return is_rem ? 32'(r) : 32'(q);
  endfunction

  // Cycles from the accepting edge until ready_o is seen.
  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (((op == DIV) || (op == REM)) && (a == SMIN) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Model: cycles left before ready, ready pulse, and the pending result.
  int          m_left = 0;
  logic        m_ready = 1'b0;
  logic [31:0] m_result = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left   <= 0;
      m_ready  <= 1'b0;
      m_result <= '0;
    end else if (cancel_i) begin
      m_left  <= 0;
      m_ready <= 1'b0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_ready <= 1'b1;
    end else if (start_i) begin
      m_result <= model_result(op_i, dividend_i, divisor_i);
      m_left   <= model_lat(op_i, dividend_i, divisor_i) - 1;
      if (model_lat(op_i, dividend_i, divisor_i) == 1) m_ready <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: pins the model, then checks the DUT every cycle.
  initial begin : compare
    logic exp_stall;
    chk("pin_divu_100_7", model_result(DIVU, 32'd100, 32'd7), 32'd14);
    chk("pin_remu_100_7", model_result(REMU, 32'd100, 32'd7), 32'd2);
    chk("pin_div_m7_2",   model_result(DIV, -32'sd7, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem_m7_2",   model_result(REM, -32'sd7, 32'd2), 32'hFFFF_FFFF);
    chk("pin_rem_7_m2",   model_result(REM, 32'd7, -32'sd2), 32'd1);
    chk("pin_div_7_m2",   model_result(DIV, 32'd7, -32'sd2), 32'hFFFF_FFFD);
    chk("pin_divu_5_0",   model_result(DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("pin_rem_5_0",    model_result(REM, 32'd5, 32'd0), 32'd5);
    chk("pin_div_ovf",    model_result(DIV, SMIN, 32'hFFFF_FFFF), SMIN);
    chk("pin_rem_ovf",    model_result(REM, SMIN, 32'hFFFF_FFFF), 32'd0);
    chk("pin_divu_20_3",  model_result(DIVU, 32'd20, 32'd3), 32'd6);
    chk("pin_divu_9_4",   model_result(DIVU, 32'd9, 32'd4), 32'd2);
    chk("pin_lat_norm",   32'(model_lat(DIVU, 32'd100, 32'd7)), 32'd33);
    chk("pin_lat_dz",     32'(model_lat(DIVU, 32'd5, 32'd0)), 32'd1);
    chk("pin_lat_ovf",    32'(model_lat(DIV, SMIN, 32'hFFFF_FFFF)), 32'd1);
    while (!tb_done) begin
      @(negedge clk);
      exp_stall = !cancel_i && (((m_left == 0) && !m_ready && start_i) || (m_left > 0));
      chk("ready_o", 32'(ready_o), 32'(m_ready));
      chk("busy_o", 32'(busy_o), 32'((m_left > 0) || m_ready));
      chk("stallreq_o", 32'(stallreq_o), 32'(exp_stall));
      if (m_ready) chk("result_o", result_o, m_result);
      else if (!rst) chk("result_o_reset", result_o, 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    repeat (n) step();
  endtask

  // Issue one divide; extra=1 when called during the previous op's ready cycle.
  // Operands are scrambled while the op runs; the DUT must ignore them.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int extra);
    int lat;
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    lat        = model_lat(op, a, b);
    for (int i = 0; i < lat + extra; i++) begin
      step();
      if ((i >= extra) && (i < lat + extra - 1)) begin
        dividend_i = $urandom;
        divisor_i  = $urandom;
        op_i       = 2'($urandom);
      end
    end
  endtask

  // Stimulus: directed corner cases, cancel, reset, then random traffic.
  initial begin : driver
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        in_done;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    step();

    run_op(DIVU, 32'd100, 32'd7, 0);                   idle(1);
    run_op(REMU, 32'd100, 32'd7, 0);                   idle(1);
    run_op(DIV, -32'sd7, 32'd2, 0);                    idle(1);
    run_op(REM, -32'sd7, 32'd2, 0);                    idle(1);
    run_op(REM, 32'd7, -32'sd2, 0);                    idle(1);
    run_op(DIV, 32'd7, -32'sd2, 0);                    idle(1);
    run_op(DIVU, 32'd5, 32'd0, 0);                     idle(1);
    run_op(REM, 32'd5, 32'd0, 0);                      idle(1);
    run_op(DIV, SMIN, 32'hFFFF_FFFF, 0);               idle(1);
    run_op(REM, SMIN, 32'hFFFF_FFFF, 0);               idle(1);

    // Flush in the middle of an iteration, start still asserted.
    start_i = 1'b1; op_i = DIV; dividend_i = 32'd123456; divisor_i = 32'd13;
    repeat (11) step();
    cancel_i = 1'b1;
    step();
    cancel_i = 1'b0;
    idle(2);
    run_op(REMU, 32'd12345, 32'd67, 0);                idle(1);

    // Asynchronous reset partway through an iteration.
    start_i = 1'b1; op_i = DIVU; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (6) step();
    rst = 1'b0;
    start_i = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    run_op(DIVU, 32'd20, 32'd3, 0);
    run_op(DIVU, 32'd9, 32'd4, 1);
    idle(2);

    in_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = SMIN; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 16);
        3: b = -32'($urandom_range(1, 16));
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      if (in_done && ($urandom_range(0, 1) == 1)) begin
        run_op(op, a, b, 1);
      end else begin
        if (in_done) idle(1 + $urandom_range(0, 2));
        run_op(op, a, b, 0);
      end
      in_done = 1'b1;
    end
    idle(3);
    tb_done = 1'b1;
  end

endmodule
